watchdog: RTL and testbench

Programmable watchdog timer on the I/O bus. Counts prescaled ticks while enabled and raises a one-cycle `timeout` pulse when software fails to reload in time. `timeout` drives one bit of the system control block's `err_sig_in` vector, which records the abort and resets the system. It sits directly upstream of that block.

---
 rtl/watchdog_pkg.sv | 35 +++
 rtl/watchdog_if.sv | 14 +
 rtl/wdog_prescaler.sv | 29 ++
 rtl/watchdog.sv | 124 ++++++++++++
 tb/tb_watchdog.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/watchdog_pkg.sv
// Shared constants and bus-access decode for the watchdog timer.
// The optional window mode is selected by the WATCHDOG_WINDOW_EN macro.
package watchdog_pkg;

  localparam logic WDOG_ADDR_CFG  = 1'b0;
  localparam logic WDOG_ADDR_STAT = 1'b1;

  localparam int WDOG_EN_BIT      = 31;
  localparam int WDOG_WIN_MSB     = 30;
  localparam int WDOG_WIN_LSB     = 16;
  localparam int WDOG_TMO_MSB     = 15;
  localparam int WDOG_TMO_LSB     = 0;
  localparam int WDOG_CNT_MSB     = 31;
  localparam int WDOG_CNT_LSB     = 16;
  localparam int WDOG_EARLY_BIT   = 1;
  localparam int WDOG_EXPIRED_BIT = 0;

  localparam int WDOG_TICK_DIV_DEFAULT = 50000;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_READ,
    ACC_CFG_WR,
    ACC_RELOAD
  } wdog_access_e;

  function automatic wdog_access_e wdog_decode(input logic stb,
                                               input logic we,
                                               input logic addr);
    if (!stb) return ACC_IDLE;
    if (!we)  return ACC_READ;
    return (addr == WDOG_ADDR_CFG) ? ACC_CFG_WR : ACC_RELOAD;
  endfunction

endpackage

// File: rtl/watchdog_if.sv
// Zero-wait-state register bus between the CPU I/O block and the watchdog.
interface watchdog_if;
  logic        stb;
  logic        we;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (output stb, output we, output addr, output data_in,
                  input  data_out, input ack);
  modport slave  (input  stb, input  we, input  addr, input  data_in,
                  output data_out, output ack);
endinterface

// File: rtl/wdog_prescaler.sv
// Divides the system clock down to one watchdog tick every TICK_DIV cycles.
module wdog_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] pre;

  assign tick = run && (pre == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (run) begin
      pre <= (pre == LAST) ? '0 : pre + W'(1);
    end
  end

endmodule

// File: rtl/watchdog.sv
// Programmable watchdog timer: counts prescaled ticks and pulses timeout
// when software misses its reload. Window mode enabled by WATCHDOG_WINDOW_EN.
module watchdog
  import watchdog_pkg::*;
#(
  parameter int TICK_DIV = WDOG_TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  watchdog_if.slave  bus,
  output logic       timeout
);

  wdog_access_e access;
  logic         en;
  logic         expired;
  logic         early;
  logic [15:0]  tmo;
  logic [15:0]  cnt;
  logic [14:0]  win_rd;
  logic         tick;
  logic         run;
  logic         clr_pre;
  logic         count_en;
  logic         expiring;
  logic         early_reload;

  assign access   = wdog_decode(bus.stb, bus.we, bus.addr);
  assign run      = en && !expired;
  assign clr_pre  = (access == ACC_CFG_WR) || (access == ACC_RELOAD);
  assign count_en = tick && (tmo != 16'd0);
  // cnt never exceeds tmo, so cnt + 1 cannot wrap here.
  assign expiring = count_en && ((cnt + 16'd1) == tmo);

  wdog_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clr  (clr_pre),
    .tick (tick)
  );

`ifdef WATCHDOG_WINDOW_EN
  logic [14:0] win;

  assign win_rd       = win;
  assign early_reload = (access == ACC_RELOAD) && en && !expired &&
                        ({1'b0, cnt} < {2'b00, win});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win   <= '0;
      early <= 1'b0;
    end else if (access == ACC_CFG_WR) begin
      win   <= bus.data_in[WDOG_WIN_MSB:WDOG_WIN_LSB];
      early <= 1'b0;
    end else if (early_reload) begin
      early <= 1'b1;
    end
  end
`else
  logic unused_win_bits;

  assign win_rd          = '0;
  assign early           = 1'b0;
  assign early_reload    = 1'b0;
  assign unused_win_bits = ^bus.data_in[WDOG_WIN_MSB:WDOG_WIN_LSB];
`endif

  // Bus writes take priority over an expiring tick in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b0;
      tmo     <= '0;
      cnt     <= '0;
      expired <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (access)
        ACC_CFG_WR: begin
          en      <= bus.data_in[WDOG_EN_BIT];
          tmo     <= bus.data_in[WDOG_TMO_MSB:WDOG_TMO_LSB];
          cnt     <= '0;
          expired <= 1'b0;
        end
        ACC_RELOAD: begin
          cnt     <= '0;
          expired <= early_reload;
          timeout <= early_reload;
        end
        default: begin
          if (expiring) begin
            cnt     <= tmo;
            expired <= 1'b1;
            timeout <= 1'b1;
          end else if (count_en) begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

  assign bus.ack = bus.stb;

  always_comb begin
    bus.data_out = '0;
    if (access == ACC_READ) begin
      if (bus.addr == WDOG_ADDR_CFG) begin
        bus.data_out[WDOG_EN_BIT]                 = en;
        bus.data_out[WDOG_WIN_MSB:WDOG_WIN_LSB]   = win_rd;
        bus.data_out[WDOG_TMO_MSB:WDOG_TMO_LSB]   = tmo;
      end else begin
        bus.data_out[WDOG_CNT_MSB:WDOG_CNT_LSB]   = cnt;
        bus.data_out[WDOG_EARLY_BIT]              = early;
        bus.data_out[WDOG_EXPIRED_BIT]            = expired;
      end
    end
  end

endmodule

// File: tb/tb_watchdog.sv
// Directed self-checking bench for the watchdog timer with TICK_DIV = 4.
module tb_watchdog;

  logic clk;
  logic rst;
  logic timeout;
  int   total;
  int   bad;

  watchdog_if bus ();

  watchdog #(
    .TICK_DIV (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] simulation time limit");
  end

  // Drive at a negedge, hold for one full cycle so the next posedge samples it.
  task automatic bus_write(input logic a, input logic [31:0] d);
    bus.stb     = 1'b1;
    bus.we      = 1'b1;
    bus.addr    = a;
    bus.data_in = d;
    @(negedge clk);
    bus.stb     = 1'b0;
    bus.we      = 1'b0;
    bus.data_in = '0;
  endtask

  // Combinational read that completes well before the next posedge.
  task automatic bus_read(input logic a, output logic [31:0] d, output logic k);
    bus.stb  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    d        = bus.data_out;
    k        = bus.ack;
    bus.stb  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        k;
    rst         = 1'b1;
    bus.stb     = 1'b0;
    bus.we      = 1'b0;
    bus.addr    = 1'b0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout);
    end
    total++;
    if (bus.data_out !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_data_out: got %h expected 00000000", bus.data_out);
    end
    total++;
    if (bus.ack !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_ack: got %b expected 0", bus.ack);
    end
    rst = 1'b0;
    @(negedge clk);
    bus_read(1'b0, rd, k);
    total++;
    if (rd !== 32'h0 || k !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_cfg_read: got %h ack %b expected 00000000 ack 1", rd, k);
    end
    bus_read(1'b1, rd, k);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_stat_read: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_expiry();
    logic [31:0] rd;
    logic        k;
    logic        exp_to;
    bus_write(1'b0, 32'h8000_0003);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      exp_to = (c == 12);
      total++;
      if (timeout !== exp_to) begin
        bad++; $display("[TB] FAIL expiry_pulse c=%0d: got %b expected %b", c, timeout, exp_to);
      end
      if (c == 12) begin
        bus_read(1'b1, rd, k);
        total++;
        if (rd !== 32'h0003_0001) begin
          bad++; $display("[TB] FAIL expiry_status: got %h expected 00030001", rd);
        end
      end
    end
    bus_read(1'b0, rd, k);
    total++;
    if (rd !== 32'h8000_0003) begin
      bad++; $display("[TB] FAIL expiry_cfg_read: got %h expected 80000003", rd);
    end
    bus_write(1'b1, 32'hFFFF_FFFF);
    bus_read(1'b1, rd, k);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("[TB] FAIL reload_clears_status: got %h expected 00000000", rd);
    end
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      exp_to = (c == 12);
      total++;
      if (timeout !== exp_to) begin
        bad++; $display("[TB] FAIL re_expiry_pulse c=%0d: got %b expected %b", c, timeout, exp_to);
      end
    end
  endtask

  task automatic test_periodic_service();
    logic [31:0] rd;
    logic        k;
    bus_write(1'b0, 32'h8000_0003);
    for (int c = 0; c < 200; c++) begin
      if (c % 8 == 7) bus_write(1'b1, 32'h0);
      else            @(negedge clk);
      total++;
      if (timeout !== 1'b0) begin
        bad++; $display("[TB] FAIL service_pulse c=%0d: got %b expected 0", c, timeout);
      end
      if (c % 25 == 3) begin
        bus_read(1'b1, rd, k);
        total++;
        if (rd[31:16] > 16'd2 || rd[0] !== 1'b0) begin
          bad++; $display("[TB] FAIL service_status c=%0d: got %h expected cnt<=2 expired=0", c, rd);
        end
      end
    end
  endtask

  task automatic test_race();
    logic [31:0] rd;
    logic        k;
    logic        exp_to;
    bus_write(1'b0, 32'h8000_0003);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      total++;
      if (timeout !== 1'b0) begin
        bad++; $display("[TB] FAIL race_pre_pulse c=%0d: got %b expected 0", c, timeout);
      end
    end
    bus_write(1'b1, 32'h0);
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL race_pulse: got %b expected 0", timeout);
    end
    bus_read(1'b1, rd, k);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("[TB] FAIL race_status: got %h expected 00000000", rd);
    end
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      exp_to = (c == 12);
      total++;
      if (timeout !== exp_to) begin
        bad++; $display("[TB] FAIL race_next_expiry c=%0d: got %b expected %b", c, timeout, exp_to);
      end
    end
  endtask

  task automatic test_degenerate();
    logic [31:0] rd;
    logic        k;
    int          pulses;
    bus_write(1'b0, 32'h8000_0000);
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (timeout === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++; $display("[TB] FAIL tmo0_pulses: got %0d expected 0", pulses);
    end
    bus_read(1'b1, rd, k);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("[TB] FAIL tmo0_status: got %h expected 00000000", rd);
    end
    bus_write(1'b0, 32'h0000_0005);
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (timeout === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++; $display("[TB] FAIL en0_pulses: got %0d expected 0", pulses);
    end
    bus_read(1'b1, rd, k);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("[TB] FAIL en0_status: got %h expected 00000000", rd);
    end
    bus_read(1'b0, rd, k);
    total++;
    if (rd !== 32'h0000_0005) begin
      bad++; $display("[TB] FAIL en0_cfg_read: got %h expected 00000005", rd);
    end
  endtask

  task automatic test_window();
    logic [31:0] rd;
    logic        k;
    bus_write(1'b0, 32'h8002_0006);
    bus_read(1'b0, rd, k);
    total++;
`ifdef WATCHDOG_WINDOW_EN
    if (rd !== 32'h8002_0006) begin
      bad++; $display("[TB] FAIL window_cfg_read: got %h expected 80020006", rd);
    end
`else
    if (rd !== 32'h8000_0006) begin
      bad++; $display("[TB] FAIL window_cfg_read: got %h expected 80000006", rd);
    end
`endif
    repeat (4) @(negedge clk);
    bus_write(1'b1, 32'h0);
    bus_read(1'b1, rd, k);
`ifdef WATCHDOG_WINDOW_EN
    total++;
    if (timeout !== 1'b1) begin
      bad++; $display("[TB] FAIL early_pulse: got %b expected 1", timeout);
    end
    total++;
    if (rd[1:0] !== 2'b11) begin
      bad++; $display("[TB] FAIL early_flags: got %b expected 11", rd[1:0]);
    end
`else
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL early_pulse: got %b expected 0", timeout);
    end
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("[TB] FAIL early_status: got %h expected 00000000", rd);
    end
`endif
    bus_write(1'b0, 32'h8002_0006);
    repeat (12) @(negedge clk);
    bus_read(1'b1, rd, k);
    total++;
    if (rd !== 32'h0003_0000) begin
      bad++; $display("[TB] FAIL window_cnt3_status: got %h expected 00030000", rd);
    end
    bus_write(1'b1, 32'h0);
    total++;
    if (timeout !== 1'b0) begin
      bad++; $display("[TB] FAIL late_reload_pulse: got %b expected 0", timeout);
    end
    bus_read(1'b1, rd, k);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("[TB] FAIL late_reload_status: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    logic        k;
    int          pulses;
    bus_write(1'b0, 32'h8000_0003);
    repeat (8) @(negedge clk);
    bus_read(1'b1, rd, k);
    total++;
    if (rd !== 32'h0002_0000) begin
      bad++; $display("[TB] FAIL pre_reset_status: got %h expected 00020000", rd);
    end
    rst = 1'b1;
    bus_read(1'b1, rd, k);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("[TB] FAIL async_reset_status: got %h expected 00000000", rd);
    end
    rst = 1'b0;
    total++;
    if (timeout !== 1'b0 || bus.data_out !== 32'h0 || bus.ack !== 1'b0) begin
      bad++; $display("[TB] FAIL async_reset_outputs: got to=%b do=%h ack=%b expected 0 0 0",
                      timeout, bus.data_out, bus.ack);
    end
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (timeout === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++; $display("[TB] FAIL post_reset_pulses: got %0d expected 0", pulses);
    end
    bus_read(1'b0, rd, k);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("[TB] FAIL post_reset_cfg: got %h expected 00000000", rd);
    end
    bus_read(1'b1, rd, k);
    total++;
    if (rd !== 32'h0) begin
      bad++; $display("[TB] FAIL post_reset_status: got %h expected 00000000", rd);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_expiry();
    test_periodic_service();
    test_race();
    test_degenerate();
    test_window();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
